// File: rtl/seg_pkg.sv
// Shared code points and active-low glyph patterns (bit 6 = a ... bit 0 = g) for the segment scanner.
// Constants only; no latency or flow control.
package seg_pkg;

    localparam logic [3:0] CODE_BLANK = 4'hA;
    localparam logic [3:0] CODE_MINUS = 4'hB;

    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h7E;

    localparam logic [6:0] GLYPH_0 = 7'h01;
    localparam logic [6:0] GLYPH_1 = 7'h4F;
    localparam logic [6:0] GLYPH_2 = 7'h12;
    localparam logic [6:0] GLYPH_3 = 7'h06;
    localparam logic [6:0] GLYPH_4 = 7'h4C;
    localparam logic [6:0] GLYPH_5 = 7'h24;
    localparam logic [6:0] GLYPH_6 = 7'h20;
    localparam logic [6:0] GLYPH_7 = 7'h0F;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h04;

endpackage

// File: rtl/seg_decode.sv
// Digit code to active-low segment pattern; a forced blank overrides the code.
// Purely combinational, no backpressure.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] code,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (!blank) begin
            case (code)
                4'd0:       seg = GLYPH_0;
                4'd1:       seg = GLYPH_1;
                4'd2:       seg = GLYPH_2;
                4'd3:       seg = GLYPH_3;
                4'd4:       seg = GLYPH_4;
                4'd5:       seg = GLYPH_5;
                4'd6:       seg = GLYPH_6;
                4'd7:       seg = GLYPH_7;
                4'd8:       seg = GLYPH_8;
                4'd9:       seg = GLYPH_9;
                CODE_MINUS: seg = SEG_MINUS;
                default:    seg = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scanner with frame-synchronous double-buffered load, leading-zero blanking and blink;
// seg/an are registered one cycle behind the scan index, no backpressure; SEG_BRIGHTNESS_PWM_EN adds anode dimming.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100_000,
    parameter int BLINK_DIV   = 50_000_000
) (
    input  logic                    clk_100MHz,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [3:0]              brightness,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    load_pending,
    output logic                    frame_start
);

    localparam int SLOT_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    localparam logic [4*NUM_DIGITS-1:0] ALL_BLANK = {NUM_DIGITS{CODE_BLANK}};

    logic [SLOT_W-1:0]       slot_cnt;
    logic [IDX_W-1:0]        scan_idx;
    logic [BLINK_W-1:0]      blink_cnt;
    logic                    blink_phase;
    logic [4*NUM_DIGITS-1:0] active;
    logic [4*NUM_DIGITS-1:0] shadow;

    logic                    slot_end;
    logic                    wrap;
    logic [NUM_DIGITS-1:0]   lz_zero;
    logic [3:0]              cur_code;
    logic                    cur_blank;
    logic [6:0]              seg_next;
    logic [NUM_DIGITS-1:0]   an_next;
    logic                    pwm_on;

    assign slot_end = (slot_cnt == SLOT_LAST);
    assign wrap     = slot_end && (scan_idx == IDX_LAST);

    // Zero run from the most significant digit downward; digit 0 is always shown.
    always_comb begin
        lz_zero = '0;
        lz_zero[NUM_DIGITS-1] = (active[4*NUM_DIGITS-1 -: 4] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 1; i--) begin
            lz_zero[i] = lz_zero[i+1] && (active[4*i +: 4] == 4'd0);
        end
    end

    assign cur_code  = active[{scan_idx, 2'b00} +: 4];
    assign cur_blank = (blank_lz && lz_zero[scan_idx])
                    || (blink_phase && blink_mask[scan_idx]);

    seg_decode u_decode (
        .code  (cur_code),
        .blank (cur_blank),
        .seg   (seg_next)
    );

`ifdef SEG_BRIGHTNESS_PWM_EN
    logic [31:0] pwm_limit;

    always_comb begin
        pwm_limit = ((32'(brightness) + 32'd1) * 32'(REFRESH_DIV)) >> 4;
        pwm_on    = (32'(slot_cnt) < pwm_limit);
    end
`else
    logic unused_brightness;

    assign unused_brightness = ^brightness;
    assign pwm_on            = 1'b1;
`endif

    assign an_next = pwm_on ? ~(NUM_DIGITS'(1) << scan_idx) : '1;

    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            slot_cnt     <= '0;
            scan_idx     <= '0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            active       <= ALL_BLANK;
            shadow       <= ALL_BLANK;
            load_pending <= 1'b0;
            seg          <= SEG_OFF;
            an           <= '1;
            frame_start  <= 1'b0;
        end else begin
            slot_cnt <= slot_end ? '0 : slot_cnt + SLOT_W'(1);
            if (slot_end) begin
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
            end

            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end

            // Active only changes at the wrap edge, so every frame is built from one data set.
            if (wrap) begin
                if (load) begin
                    active <= digits_in;
                end else if (load_pending) begin
                    active <= shadow;
                end
                load_pending <= 1'b0;
            end else if (load) begin
                shadow       <= digits_in;
                load_pending <= 1'b1;
            end

            seg         <= seg_next;
            an          <= an_next;
            frame_start <= (slot_cnt == '0) && (scan_idx == '0);
        end
    end

endmodule
